// File: rtl/ifu_fetch_pkg.sv
// Shared constants for the instruction fetch unit: datapath width, FSM
// encodings, reset instruction and the PC step helper.
package ifu_fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] IFU_ST_IDLE = 3'd0;
    localparam logic [2:0] IFU_ST_REQ  = 3'd1;
    localparam logic [2:0] IFU_ST_WAIT = 3'd2;
    localparam logic [2:0] IFU_ST_HOLD = 3'd3;
    localparam logic [2:0] IFU_ST_DROP = 3'd4;

    localparam logic [31:0]     NOP_INST = 32'h0000_0013;
    localparam logic            TRUE     = 1'b1;
    localparam logic            FALSE    = 1'b0;
    localparam logic [XLEN-1:0] ZEROWORD = '0;

    // Sequential fetch step; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit: issues one imem request at a time,
// holds the returned instruction for decode and handles branch/jump redirects.
//
// state | meaning
// IDLE  | no request; waiting for stall to clear
// REQ   | request asserted on imem until accepted
// WAIT  | request accepted, waiting for the response
// HOLD  | instruction presented to decode until id_ready
// DROP  | redirected while a response is still due; discard it
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bj_taken,
    input  logic [XLEN-1:0] bj_addr,
    input  logic            stall,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_inst,
    input  logic            id_ready
);

    logic [2:0]      state;
    logic [XLEN-1:0] fetch_pc;

    assign imem_req_valid = (state == IFU_ST_REQ)  ? TRUE : FALSE;
    assign if_valid       = (state == IFU_ST_HOLD) ? TRUE : FALSE;
    assign imem_req_addr  = fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IFU_ST_IDLE;
            fetch_pc <= RESET_PC;
            if_pc    <= ZEROWORD;
            if_inst  <= NOP_INST;
        end else begin
            // A redirect overrides stall, handoff and the sequential increment.
            if (bj_taken)
                fetch_pc <= bj_addr;

            case (state)
                IFU_ST_IDLE: begin
                    if (bj_taken || !stall)
                        state <= IFU_ST_REQ;
                end
                IFU_ST_REQ: begin
                    if (imem_req_ready)
                        state <= bj_taken ? IFU_ST_DROP : IFU_ST_WAIT;
                end
                IFU_ST_WAIT: begin
                    if (bj_taken) begin
                        state <= imem_rsp_valid ? IFU_ST_REQ : IFU_ST_DROP;
                    end else if (imem_rsp_valid) begin
                        if_inst <= imem_rsp_data;
                        if_pc   <= fetch_pc;
                        state   <= IFU_ST_HOLD;
                    end
                end
                IFU_ST_HOLD: begin
                    if (bj_taken) begin
                        state <= IFU_ST_REQ;
                    end else if (id_ready) begin
                        fetch_pc <= next_pc(fetch_pc);
                        state    <= stall ? IFU_ST_IDLE : IFU_ST_REQ;
                    end
                end
                IFU_ST_DROP: begin
                    if (imem_rsp_valid)
                        state <= (bj_taken || !stall) ? IFU_ST_REQ : IFU_ST_IDLE;
                end
                default: state <= IFU_ST_IDLE;
            endcase
        end
    end

endmodule
